uart_cmd_tx: RTL and testbench
==============================

UART_CMD_TX -- requirements
Module: uart_cmd_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of every serialized frame payload.
REQ-002 Parameter CMD_WR_CODE, default 8'hAA: command frame for a register-file write.
REQ-003 Parameter CMD_RD_CODE, default 8'hBB: command frame for a register-file read.
REQ-004 CLK  input  1: single clock; every register is clocked on its rising edge.
REQ-005 RST  input  1: reset, asynchronous, active-high.
REQ-006 CMD_VALID  input  1: a command request is present.
REQ-007 CMD_READY  output  1: the block can accept a command.
REQ-008 CMD_TYPE  input  1: 1 = write (3 frames), 0 = read (2 frames).
REQ-009 CMD_ADDR  input  DATA_WIDTH: register address.
REQ-010 CMD_DATA  input  DATA_WIDTH: write data, ignored for reads.
REQ-011 PAR_MODE  input  2: 2'b00 disabled, 2'b10 even, 2'b11 odd; 2'b01 is treated as disabled.
REQ-012 PRESCALE  input  6: CLK cycles per UART bit period.
REQ-013 TX_OUT  output  1: serial line, idle high.
REQ-014 BUSY  output  1: a transaction is in progress.
REQ-015 DONE  output  1: one-cycle pulse when the final stop bit completes.

Function
REQ-016 Handshake: accept on the rising edge where CMD_VALID and CMD_READY are both 1; CMD_READY = 1 only in IDLE.
REQ-017 At acceptance, latch CMD_TYPE, CMD_ADDR, CMD_DATA, PAR_MODE and PRESCALE; input changes during a transaction have no effect.
REQ-018 Frame sequence: write = CMD_WR_CODE, CMD_ADDR, CMD_DATA; read = CMD_RD_CODE, CMD_ADDR.
REQ-019 Each frame is, in order: 1 idle bit (high), start (0), DATA_WIDTH data bits LSB first, parity bit if enabled, stop (1).
REQ-020 Parity bit: even = XOR of the data bits; odd = XNOR of the data bits.
REQ-021 Each bit period lasts exactly PRESCALE CLK cycles, and PRESCALE = 0 gives 64 cycles.
REQ-022 FSM states: IDLE, GAP, START, DATA, PARITY, STOP.
REQ-023 Transitions: IDLE->GAP on acceptance; GAP->START->DATA; DATA->PARITY (parity enabled) or DATA->STOP (disabled) after DATA_WIDTH bits; STOP->GAP if frames remain, otherwise STOP->IDLE.
REQ-024 Latency: the first GAP cycle is the cycle after acceptance, and the start bit begins PRESCALE cycles later.
REQ-025 Transaction length is frames x (11 with parity disabled, 12 with parity enabled) x PRESCALE cycles, measured from the first GAP cycle to the end of the last stop bit.
REQ-026 DONE is 1 for exactly the first IDLE cycle after the last STOP, and CMD_READY is 1 in that same cycle.
REQ-027 If CMD_VALID is held high, the next command is accepted in the DONE cycle, so back-to-back commands have no extra idle cycles beyond the GAP bit.
REQ-028 TX_OUT is registered (glitch-free) and is 1 in IDLE, GAP and STOP.
REQ-029 BUSY = 1 in every non-IDLE state.

Reset
REQ-030 RST asserted: immediately force state IDLE, TX_OUT = 1, CMD_READY = 1, BUSY = 0, DONE = 0, and clear the frame, bit and prescale counters.
REQ-031 RST asserted mid-frame aborts the transaction with no DONE, and the line returns high at once.
REQ-032 After RST deasserts, a new command is accepted on the first rising edge with CMD_VALID = 1.

Structure
REQ-033 The shared package shall hold the command codes (8'hAA, 8'hBB), the PAR_MODE encodings and the FSM state enum.
REQ-034 One sub-module, uart_frame_tx, shall serialize one frame (gap/start/data/parity/stop with its bit timer).
REQ-035 The top level shall sequence frames and own the handshake.

Verification
REQ-036 Write addr 8'h05, data 8'hA6, even parity, PRESCALE 32 -> frames AA, 05, A6, each with parity 0; DONE exactly 1152 cycles after the first GAP cycle.
REQ-037 Read addr 8'h05, odd parity, PRESCALE 32 -> frames BB, 05, each with parity 1; 768 cycles from the first GAP cycle to DONE.
REQ-038 Write 8'h3C/8'hFF, parity disabled, PRESCALE 8 -> 11-bit frames with no parity slot; 264 cycles total.
REQ-039 CMD_VALID held high for two commands -> second acceptance in the DONE cycle; TX_OUT stays 1 between the two transactions for exactly one bit period.
REQ-040 RST pulsed during the DATA bit 3 of frame 2 -> TX_OUT = 1 and CMD_READY = 1 immediately, no DONE; a following read transmits correctly.
REQ-041 Loopback of TX_OUT into SYS_TOP RX_IN (PRESCALE 32, even parity) -> write 8'hA6 to address 5, then read address 5 returns 8'hA6 on TX_OUT with RX_ERROR = 0.

Source files
------------

// File: rtl/uart_cmd_tx_pkg.sv
// Shared definitions for the UART command transmitter: default command codes,
// parity-mode encodings and the serializer state enum.
package uart_cmd_tx_pkg;

    localparam logic [7:0] CMD_WR_DEFAULT = 8'hAA;
    localparam logic [7:0] CMD_RD_DEFAULT = 8'hBB;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_NONE_ALT = 2'b01,
        PAR_EVEN     = 2'b10,
        PAR_ODD      = 2'b11
    } par_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Only the two modes with the MSB set carry a parity bit.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// Serializes one frame: gap, start, data LSB first, optional parity, stop.
// A start request during the final stop cycle chains straight into the next gap.
module uart_frame_tx
    import uart_cmd_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [1:0]            par_mode_i,
    input  logic [5:0]            prescale_i,
    output logic                  line_o,
    output logic                  frame_done_o,
    output logic                  busy_o
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_e       state_q, state_d;
    logic [CW-1:0]   bit_q, bit_d;
    logic [5:0]      tick_q, tick_d;
    logic            line_q, line_d;
    logic            bit_end;
    logic            last_bit;
    logic            par_bit;

    // A prescale of 0 wraps to 63, giving a 64-cycle bit period for free.
    assign bit_end      = (tick_q == prescale_i - 6'd1);
    assign last_bit     = (bit_q == CW'(DATA_WIDTH - 1));
    assign par_bit      = (^data_i) ^ (par_mode_i == PAR_ODD);
    assign frame_done_o = (state_q == ST_STOP) && bit_end;
    assign busy_o       = (state_q != ST_IDLE);
    assign line_o       = line_q;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        tick_d  = (state_q == ST_IDLE || bit_end) ? 6'd0 : tick_q + 6'd1;
        case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_GAP;
            ST_GAP:    if (bit_end) state_d = ST_START;
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (last_bit)
                        state_d = parity_enabled(par_mode_i) ? ST_PARITY : ST_STOP;
                    else
                        bit_d = bit_q + 1'b1;
                end
            end
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP:   if (bit_end) state_d = start_i ? ST_GAP : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = data_i[bit_d];
            ST_PARITY: line_d = par_bit;
            default:   line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            tick_q  <= '0;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            tick_q  <= tick_d;
            line_q  <= line_d;
        end
    end

endmodule

// File: rtl/uart_cmd_tx.sv
// Register-file command transmitter: owns the command handshake and sequences
// the code/address/data frames through a single frame serializer.
module uart_cmd_tx
    import uart_cmd_tx_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] CMD_WR_CODE = DATA_WIDTH'(CMD_WR_DEFAULT),
    parameter logic [DATA_WIDTH-1:0] CMD_RD_CODE = DATA_WIDTH'(CMD_RD_DEFAULT)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_TYPE,
    input  logic [DATA_WIDTH-1:0] CMD_ADDR,
    input  logic [DATA_WIDTH-1:0] CMD_DATA,
    input  logic [1:0]            PAR_MODE,
    input  logic [5:0]            PRESCALE,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  DONE
);

    logic                  type_q, type_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            par_q, par_d;
    logic [5:0]            pre_q, pre_d;
    logic [1:0]            idx_q, idx_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  frame_busy;
    logic                  frame_done;
    logic                  last_frame;
    logic                  next_frame;
    logic [DATA_WIDTH-1:0] frame_byte;

    assign CMD_READY  = !frame_busy;
    assign BUSY       = frame_busy;
    assign DONE       = done_q;
    assign accept     = CMD_VALID && CMD_READY;
    assign last_frame = (idx_q == (type_q ? 2'd2 : 2'd1));
    assign next_frame = frame_done && !last_frame;

    always_comb begin
        case (idx_q)
            2'd0:    frame_byte = type_q ? CMD_WR_CODE : CMD_RD_CODE;
            2'd1:    frame_byte = addr_q;
            default: frame_byte = data_q;
        endcase
    end

    always_comb begin
        type_d = type_q;
        addr_d = addr_q;
        data_d = data_q;
        par_d  = par_q;
        pre_d  = pre_q;
        idx_d  = idx_q;
        done_d = frame_done && last_frame;
        if (accept) begin
            type_d = CMD_TYPE;
            addr_d = CMD_ADDR;
            data_d = CMD_DATA;
            par_d  = PAR_MODE;
            pre_d  = PRESCALE;
            idx_d  = 2'd0;
        end else if (next_frame) begin
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            type_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            par_q  <= PAR_NONE;
            pre_q  <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            type_q <= type_d;
            addr_q <= addr_d;
            data_q <= data_d;
            par_q  <= par_d;
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            done_q <= done_d;
        end
    end

    // The serializer reads the latched settings, which are valid from the first gap cycle on.
    uart_frame_tx #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_frame (
        .clk          (CLK),
        .rst          (RST),
        .start_i      (accept || next_frame),
        .data_i       (frame_byte),
        .par_mode_i   (par_q),
        .prescale_i   (pre_q),
        .line_o       (TX_OUT),
        .frame_done_o (frame_done),
        .busy_o       (frame_busy)
    );

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Randomized bench for uart_cmd_tx: each command's line waveform is compared
// against a bit-list model built from the frame format, then decoded mid-bit.
module tb_uart_cmd_tx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic       CMD_TYPE;
    logic [7:0] CMD_ADDR;
    logic [7:0] CMD_DATA;
    logic [1:0] PAR_MODE;
    logic [5:0] PRESCALE;
    logic       TX_OUT;
    logic       BUSY;
    logic       DONE;

    int n_checks = 0;
    int n_errors = 0;
    bit prev_hold = 1'b0;

    uart_cmd_tx dut (
        .CLK       (CLK),
        .RST       (RST),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_TYPE  (CMD_TYPE),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_DATA  (CMD_DATA),
        .PAR_MODE  (PAR_MODE),
        .PRESCALE  (PRESCALE),
        .TX_OUT    (TX_OUT),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge. hold keeps CMD_VALID high so the next
    // call's command is taken in the DONE cycle. abort_at >= 0 pulses reset at
    // that cycle offset from the first gap cycle and ends the transaction there.
    task automatic run_cmd(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                           input logic [1:0] pm, input logic [5:0] pre,
                           input bit hold, input int abort_at);
        int         p;
        int         nf;
        int         bits;
        int         w;
        int         cyc;
        int         busy_bad;
        int         wave_bad;
        int         done_seen;
        int         ones;
        int         pos;
        bit         pen;
        logic [7:0] fr [3];
        logic [7:0] dec;
        logic       par_exp;
        logic       par_got;
        logic       exp_q [$];
        logic       cap [$];

        p    = (pre == 6'd0) ? 64 : int'(pre);
        nf   = wr ? 3 : 2;
        pen  = pm[1];
        bits = pen ? 12 : 11;
        fr[0] = wr ? 8'hAA : 8'hBB;
        fr[1] = addr;
        fr[2] = data;

        for (int f = 0; f < nf; f++) begin
            ones = 0;
            for (int i = 0; i < 8; i++) ones += fr[f][i];
            par_exp = (pm == 2'b11) ? logic'(1 - ones % 2) : logic'(ones % 2);
            for (int k = 0; k < p; k++) exp_q.push_back(1'b1);
            for (int k = 0; k < p; k++) exp_q.push_back(1'b0);
            for (int i = 0; i < 8; i++)
                for (int k = 0; k < p; k++) exp_q.push_back(fr[f][i]);
            if (pen)
                for (int k = 0; k < p; k++) exp_q.push_back(par_exp);
            for (int k = 0; k < p; k++) exp_q.push_back(1'b1);
        end

        CMD_VALID = 1'b1;
        CMD_TYPE  = wr;
        CMD_ADDR  = addr;
        CMD_DATA  = data;
        PAR_MODE  = pm;
        PRESCALE  = pre;
        w = 0;
        while (!CMD_READY && w < 5000) begin
            @(negedge CLK);
            w++;
        end
        chk("ready_wait", (w < 5000) ? 32'd1 : 32'd0, 32'd1);
        if (prev_hold) chk("b2b_accept_in_done_cycle", w, 0);
        @(posedge CLK);
        @(negedge CLK);
        CMD_VALID = hold;
        CMD_TYPE  = 1'($urandom);
        CMD_ADDR  = 8'($urandom);
        CMD_DATA  = 8'($urandom);
        PAR_MODE  = 2'($urandom);
        PRESCALE  = 6'($urandom);

        cyc = 0;
        busy_bad = 0;
        while (!DONE && cyc < 5000) begin
            cap.push_back(TX_OUT);
            if (!BUSY || CMD_READY) busy_bad++;
            if (cyc == abort_at) begin
                #1 RST = 1'b1;
                #1;
                chk("abort_tx_high", TX_OUT, 1);
                chk("abort_ready", CMD_READY, 1);
                chk("abort_busy", BUSY, 0);
                chk("abort_done", DONE, 0);
                @(negedge CLK);
                RST = 1'b0;
                CMD_VALID = 1'b0;
                done_seen = 0;
                for (int k = 0; k < 3 * p; k++) begin
                    @(negedge CLK);
                    if (DONE || BUSY || !TX_OUT) done_seen++;
                end
                chk("abort_quiet_after", done_seen, 0);
                prev_hold = 1'b0;
                return;
            end
            cyc++;
            @(negedge CLK);
        end
        chk("done_timeout", (cyc < 5000) ? 32'd1 : 32'd0, 32'd1);
        chk("txn_length", cap.size(), nf * bits * p);
        chk("busy_ready_during_txn", busy_bad, 0);
        chk("done_cycle_tx_high", TX_OUT, 1);
        chk("done_cycle_ready", CMD_READY, 1);

        wave_bad = 0;
        for (int k = 0; k < exp_q.size(); k++)
            if (k >= cap.size() || cap[k] !== exp_q[k]) wave_bad++;
        chk("waveform_mismatch_cycles", wave_bad, 0);

        for (int f = 0; f < nf; f++) begin
            dec = 8'h00;
            for (int i = 0; i < 8; i++) begin
                pos = f * bits * p + (2 + i) * p + p / 2;
                dec[i] = (pos < cap.size()) ? cap[pos] : 1'bx;
            end
            chk($sformatf("frame%0d_byte", f), dec, fr[f]);
            if (pen) begin
                ones = 0;
                for (int i = 0; i < 8; i++) ones += fr[f][i];
                par_exp = (pm == 2'b11) ? logic'(1 - ones % 2) : logic'(ones % 2);
                pos = f * bits * p + 10 * p + p / 2;
                par_got = (pos < cap.size()) ? cap[pos] : 1'bx;
                chk($sformatf("frame%0d_parity", f), par_got, par_exp);
            end
        end
        $display("txn wr=%0d addr=%02h data=%02h par=%0d pre=%0d hold=%0d cycles=%0d",
                 wr, addr, data, pm, p, hold, cap.size());

        prev_hold = hold;
        if (!hold) begin
            CMD_VALID = 1'b0;
            @(negedge CLK);
            chk("done_one_cycle", DONE, 0);
        end
    endtask

    initial begin
        RST       = 1'b1;
        CMD_VALID = 1'b0;
        CMD_TYPE  = 1'b0;
        CMD_ADDR  = 8'h00;
        CMD_DATA  = 8'h00;
        PAR_MODE  = 2'b00;
        PRESCALE  = 6'd0;
        repeat (2) @(negedge CLK);
        chk("reset_tx", TX_OUT, 1);
        chk("reset_ready", CMD_READY, 1);
        chk("reset_busy", BUSY, 0);
        chk("reset_done", DONE, 0);
        RST = 1'b0;
        @(negedge CLK);

        run_cmd(1'b1, 8'h05, 8'hA6, 2'b10, 6'd32, 1'b0, -1);
        run_cmd(1'b0, 8'h05, 8'h00, 2'b11, 6'd32, 1'b0, -1);
        run_cmd(1'b1, 8'h3C, 8'hFF, 2'b00, 6'd8,  1'b0, -1);
        run_cmd(1'b0, 8'h77, 8'h00, 2'b01, 6'd0,  1'b0, -1);
        run_cmd(1'b1, 8'h12, 8'h34, 2'b10, 6'd4,  1'b1, -1);
        run_cmd(1'b0, 8'h56, 8'h00, 2'b11, 6'd4,  1'b0, -1);
        // Abort in the middle of data bit 3 (a 0 bit) of the address frame.
        run_cmd(1'b1, 8'h05, 8'hC3, 2'b10, 6'd8,  1'b0, 12 * 8 + 5 * 8 + 4);
        run_cmd(1'b0, 8'h05, 8'h00, 2'b11, 6'd8,  1'b0, -1);

        for (int t = 0; t < 15; t++) begin
            logic [5:0] pre_r;
            pre_r = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 10));
            run_cmd(1'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), pre_r,
                    ($urandom_range(0, 3) == 0), -1);
        end
        run_cmd(1'b1, 8'hFE, 8'h01, 2'b11, 6'd1, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
